// File: rtl/mu0_mem_arbiter.sv
// Two-port arbiter sharing one single-port 4K x 16 synchronous RAM between the MU0 CPU and a host.
// Each grant runs IDLE -> ACCESS -> DONE, so at most one transfer completes every three cycles.
module mu0_mem_arbiter #(
    parameter int unsigned PRIORITY = 0,
    parameter logic [3:0]  MAX_WAIT = 4'd3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_rdata_o,

    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [11:0] host_addr_i,
    input  logic [15:0] host_wdata_i,
    output logic        host_ack_o,
    output logic [15:0] host_rdata_o,

    output logic [11:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [15:0] mem_rdata_i,

    output logic        busy_o,
    output logic        owner_host_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    // In the fixed-priority modes, which port is the high-priority one.
    localparam logic HostHigh = (PRIORITY == 32'd2);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] wait_q, wait_d;

    logic grant_host;
    logic low_req;
    logic any_req;

    assign any_req = cpu_req_i | host_req_i;
    assign low_req = HostHigh ? cpu_req_i : host_req_i;

    always_comb begin
        grant_host = host_req_i;
        if (cpu_req_i && host_req_i) begin
            if (PRIORITY == 32'd0) begin
                grant_host = ~owner_q;
            end else if ((MAX_WAIT != 4'd0) && (wait_q == MAX_WAIT)) begin
                grant_host = ~HostHigh;
            end else begin
                grant_host = HostHigh;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wait_d  = wait_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    owner_d = grant_host;
                    if (PRIORITY != 32'd0) begin
                        // Count only grants that made a pending low-priority port wait.
                        if ((grant_host == HostHigh) && low_req) begin
                            wait_d = (wait_q == MAX_WAIT) ? wait_q : wait_q + 4'd1;
                        end else begin
                            wait_d = 4'd0;
                        end
                    end
                end
            end
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= 1'b1;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        mem_addr_o  = 12'd0;
        mem_wdata_o = 16'd0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        if (state_q == StAccess) begin
            mem_addr_o  = owner_q ? host_addr_i  : cpu_addr_i;
            mem_wdata_o = owner_q ? host_wdata_i : cpu_wdata_i;
            mem_write_o = owner_q ? host_we_i    : cpu_we_i;
            mem_read_o  = ~mem_write_o;
        end
    end

    assign cpu_ack_o    = (state_q == StDone) & ~owner_q;
    assign host_ack_o   = (state_q == StDone) &  owner_q;
    assign cpu_rdata_o  = mem_rdata_i;
    assign host_rdata_o = mem_rdata_i;
    assign busy_o       = (state_q != StIdle);
    assign owner_host_o = owner_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: three instances (round-robin, CPU-priority, host-priority without guard),
// directed checks followed by random traffic scored against a transaction-level model.
module tb_mu0_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req [N];
    logic        cpu_we [N];
    logic [11:0] cpu_addr [N];
    logic [15:0] cpu_wdata [N];
    logic        cpu_ack [N];
    logic [15:0] cpu_rdata [N];
    logic        host_req [N];
    logic        host_we [N];
    logic [11:0] host_addr [N];
    logic [15:0] host_wdata [N];
    logic        host_ack [N];
    logic [15:0] host_rdata [N];
    logic [11:0] mem_addr [N];
    logic [15:0] mem_wdata [N];
    logic        mem_read [N];
    logic        mem_write [N];
    logic        busy [N];
    logic        owner_host [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit sb_en = 1'b0;

    function automatic logic [15:0] init_val(input logic [11:0] a);
        return (a == 12'h005) ? 16'h1234 : (({4'h0, a} * 16'd37) ^ 16'h5A5A);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [15:0] rd_q;
        logic [15:0] ram [int];

        mu0_mem_arbiter #(
            .PRIORITY(g),
            .MAX_WAIT((g == 2) ? 4'd0 : 4'd3)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .cpu_req_i(cpu_req[g]), .cpu_we_i(cpu_we[g]), .cpu_addr_i(cpu_addr[g]),
            .cpu_wdata_i(cpu_wdata[g]), .cpu_ack_o(cpu_ack[g]), .cpu_rdata_o(cpu_rdata[g]),
            .host_req_i(host_req[g]), .host_we_i(host_we[g]), .host_addr_i(host_addr[g]),
            .host_wdata_i(host_wdata[g]), .host_ack_o(host_ack[g]), .host_rdata_o(host_rdata[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_read_o(mem_read[g]),
            .mem_write_o(mem_write[g]), .mem_rdata_i(rd_q),
            .busy_o(busy[g]), .owner_host_o(owner_host[g])
        );

        always @(posedge clk) begin
            if (mem_write[g]) ram[int'(mem_addr[g])] = mem_wdata[g];
            if (mem_read[g]) begin
                rd_q <= ram.exists(int'(mem_addr[g])) ? ram[int'(mem_addr[g])]
                                                      : init_val(mem_addr[g]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input bit host, input logic req, input logic we,
                           input logic [11:0] addr, input logic [15:0] wdata);
        if (host) begin
            host_req[k] = req; host_we[k] = we; host_addr[k] = addr; host_wdata[k] = wdata;
        end else begin
            cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata;
        end
    endtask

    // Transaction-level model: one grant per free slot, slot busy for three cycles.
    typedef struct {
        bit          host;
        bit          we;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sbq [N][$];
    logic [15:0] mram [N][4096];
    bit          mram_ok = 1'b0;
    int          phase [N];
    bit          last_host [N];
    int          streak [N];

    always @(posedge clk) begin : model
        bit hi, win, lowp;
        int mw;
        logic [11:0] a;
        exp_t e;
        cyc = cyc + 1;
        for (int k = 0; k < N; k++) begin
            mw = (k == 2) ? 0 : 3;
            hi = (k == 2);
            if (rst || !sb_en) begin
                phase[k] = 0; last_host[k] = 1'b1; streak[k] = 0; sbq[k].delete();
                if (!mram_ok) for (int i = 0; i < 4096; i++) mram[k][i] = init_val(12'(i));
            end else if (phase[k] > 0) begin
                phase[k] = phase[k] - 1;
            end else if (cpu_req[k] || host_req[k]) begin
                if (!(cpu_req[k] && host_req[k])) win = host_req[k];
                else if (k == 0) win = !last_host[k];
                else win = (mw != 0 && streak[k] == mw) ? !hi : hi;
                if (k != 0) begin
                    lowp = hi ? cpu_req[k] : host_req[k];
                    streak[k] = (win == hi && lowp) ? ((streak[k] < mw) ? streak[k] + 1 : mw) : 0;
                end
                last_host[k] = win;
                e.host = win;
                e.we = win ? host_we[k] : cpu_we[k];
                a = win ? host_addr[k] : cpu_addr[k];
                e.rdata = e.we ? 16'h0 : mram[k][a];
                if (e.we) mram[k][a] = win ? host_wdata[k] : cpu_wdata[k];
                e.cyc = cyc + 1;
                sbq[k].push_back(e);
                phase[k] = 2;
            end
        end
        mram_ok = 1'b1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_en && !rst) begin
            for (int k = 0; k < N; k++) begin
                if (cpu_ack[k] || host_ack[k]) begin
                    if (sbq[k].size() == 0) begin
                        check($sformatf("i%0d_unexpected_ack", k), {cpu_ack[k], host_ack[k]}, 0);
                    end else begin
                        e = sbq[k].pop_front();
                        check($sformatf("i%0d_ack_port", k), {cpu_ack[k], host_ack[k]},
                              e.host ? 32'd1 : 32'd2);
                        check($sformatf("i%0d_ack_cycle", k), cyc, e.cyc);
                        if (!e.we) check($sformatf("i%0d_rdata", k),
                                         e.host ? host_rdata[k] : cpu_rdata[k], e.rdata);
                    end
                end else if (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
                    e = sbq[k].pop_front();
                    check($sformatf("i%0d_missing_ack", k), {cpu_ack[k], host_ack[k]},
                          e.host ? 32'd1 : 32'd2);
                end
            end
        end
    end

    task automatic drive_port(input int k, input bit host, input int n);
        logic got;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(k, host, 1'b0, 1'b0, 12'h0, 16'h0);
                repeat (gap) @(posedge clk);
                #1;
            end
            set_req(k, host, 1'b1, 1'($urandom_range(0, 1)),
                    12'h010 + 12'($urandom_range(0, 15)), 16'($urandom));
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(posedge clk);
                #1;
                got = host ? host_ack[k] : cpu_ack[k];
            end
            check($sformatf("i%0d_%s_ack_wait", k, host ? "host" : "cpu"), got, 1);
        end
        set_req(k, host, 1'b0, 1'b0, 12'h0, 16'h0);
    endtask

    task automatic do_xfer(input int k, input bit host, input logic we, input logic [11:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rd, output logic got,
                           output logic clash);
        set_req(k, host, 1'b1, we, addr, wdata);
        got = 1'b0; clash = 1'b0; rd = 16'h0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(posedge clk);
            #1;
            if (cpu_ack[k] && host_ack[k]) clash = 1'b1;
            if (host ? host_ack[k] : cpu_ack[k]) begin
                got = 1'b1;
                rd = host ? host_rdata[k] : cpu_rdata[k];
            end
        end
        set_req(k, host, 1'b0, 1'b0, 12'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] rd;
        logic got, clash;
        int n [N];
        bit seq [N][8];
        bit exp_h;

        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
            set_req(k, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("i%0d_rst_busy", k), busy[k], 0);
            check($sformatf("i%0d_rst_acks", k), {cpu_ack[k], host_ack[k]}, 0);
            check($sformatf("i%0d_rst_strobes", k), {mem_read[k], mem_write[k]}, 0);
            check($sformatf("i%0d_rst_owner", k), owner_host[k], 1);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // CPU read of a preset word: strobe one cycle after request, ack the cycle after.
        set_req(0, 1'b0, 1'b1, 1'b0, 12'h005, 16'h0);
        @(posedge clk);
        #1;
        check("rd_mem_read", {mem_read[0], mem_write[0]}, 2'b10);
        check("rd_mem_addr", mem_addr[0], 12'h005);
        check("rd_busy_owner", {busy[0], owner_host[0]}, 2'b10);
        @(posedge clk);
        #1;
        check("rd_cpu_ack", {cpu_ack[0], host_ack[0]}, 2'b10);
        check("rd_cpu_rdata", cpu_rdata[0], 16'h1234);
        set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
        @(posedge clk);
        #1;
        check("rd_back_idle", {busy[0], cpu_ack[0]}, 0);

        // Asynchronous reset in the middle of a write access.
        set_req(0, 1'b0, 1'b1, 1'b1, 12'h0F0, 16'h5555);
        @(posedge clk);
        #1;
        check("mid_wr_strobe", {mem_write[0], mem_wdata[0]}, {1'b1, 16'h5555});
        rst = 1'b1;
        #1;
        check("mid_rst_strobe", {mem_read[0], mem_write[0]}, 0);
        check("mid_rst_busy_ack", {busy[0], cpu_ack[0], host_ack[0]}, 0);
        set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_idle", {busy[0], cpu_ack[0], owner_host[0]}, 3'b001);

        // Host writes, CPU reads the same word back.
        do_xfer(0, 1'b1, 1'b1, 12'h0FF, 16'hBEEF, rd, got, clash);
        check("hw_host_ack", {got, clash}, 2'b10);
        do_xfer(0, 1'b0, 1'b0, 12'h0FF, 16'h0, rd, got, clash);
        check("hr_cpu_ack", {got, clash}, 2'b10);
        check("hr_cpu_rdata", rd, 16'hBEEF);

        // Grant order with both ports requesting continuously from reset.
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0);
            set_req(k, 1'b1, 1'b1, 1'b0, 12'h021, 16'h0);
            n[k] = 0;
        end
        @(negedge clk) rst = 1'b0;
        repeat (24) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (cpu_ack[k] || host_ack[k]) begin
                    check($sformatf("i%0d_order_single_ack", k), cpu_ack[k] & host_ack[k], 0);
                    if (n[k] < 8) seq[k][n[k]] = host_ack[k];
                    n[k]++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            check($sformatf("i%0d_order_count", k), n[k], 8);
            for (int i = 0; i < 8 && i < n[k]; i++) begin
                exp_h = (k == 0) ? (i % 2 == 1) : (k == 1) ? (i % 4 == 3) : 1'b1;
                check($sformatf("i%0d_order_%0d", k, i), seq[k][i], exp_h);
            end
            set_req(k, 1'b0, 1'b0, 1'b0, 12'h0, 16'h0);
            set_req(k, 1'b1, 1'b0, 1'b0, 12'h0, 16'h0);
        end

        // Random traffic on all instances, scored by the model.
        rst = 1'b1;
        sb_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        fork
            drive_port(0, 1'b0, 40);
            drive_port(0, 1'b1, 40);
            drive_port(1, 1'b0, 40);
            drive_port(1, 1'b1, 40);
            drive_port(2, 1'b0, 40);
            drive_port(2, 1'b1, 40);
        join
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check($sformatf("i%0d_sb_drain", k), sbq[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
